int_controller: RTL and testbench

Prioritised interrupt controller that sits beside the sequencing controller and feeds its `intPending` input. It latches rising edges on `N` interrupt lines into pending bits and applies a software-loaded mask and a global enable. It then presents the highest-priority eligible request as a single frozen vector address (HVPI address), and tracks one in-service interrupt at a time. The controller's `clrPend` acknowledges the request; `intReturn` ends service.

---
 rtl/int_controller.sv | 139 +++++++++++++
 tb/tb_int_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// Prioritised interrupt controller: captures rising edges on N lines,
// applies mask and global enable, presents the highest-priority eligible
// line as a frozen vector address and tracks a single in-service interrupt.
module int_controller #(
    parameter int unsigned     N          = 8,
    parameter int unsigned     AW         = 16,
    parameter logic [AW-1:0]   VEC_BASE   = 16'hFF00,
    parameter int unsigned     VEC_STRIDE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  irq,
    input  logic [N-1:0]  maskIn,
    input  logic          MASKld,
    input  logic          MASKclr,
    input  logic          intDisable,
    input  logic          intEnable,
    input  logic          clrPend,
    input  logic          intReturn,
    output logic          intPending,
    output logic [AW-1:0] hvpiAddr,
    output logic          inService,
    output logic [N-1:0]  pendingOut,
    output logic [N-1:0]  maskOut
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SERVICE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    irq_prev_q;
    logic [N-1:0]    pend_q, pend_d;
    logic [N-1:0]    mask_q, mask_d;
    logic            en_q, en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   sel_q, sel_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    eligible;
    logic [N-1:0]    clr_vec;
    logic [IW-1:0]   sel_idx;
    logic            found;

    // Edge detect, eligibility, lowest-index priority pick, mask and enable updates
    always_comb begin
        rise     = irq & ~irq_prev_q;
        eligible = pend_q & ~mask_q;
        sel_idx  = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
                sel_idx = IW'(i);
                found   = 1'b1;
            end
        end

        mask_d = mask_q;
        if (MASKclr) begin
            mask_d = '0;
        end else if (MASKld) begin
            mask_d = maskIn;
        end

        en_d = en_q;
        if (intDisable) begin
            en_d = 1'b0;
        end else if (intEnable) begin
            en_d = 1'b1;
        end
    end

    // Request/service FSM; a new rising edge beats the acknowledge clear of the same bit
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        clr_vec = '0;
        unique case (state_q)
            IDLE: begin
                if (en_q && found) begin
                    state_d = PEND;
                    sel_d   = sel_idx;
                    addr_d  = VEC_BASE + AW'(sel_idx) * AW'(VEC_STRIDE);
                end
            end
            PEND: begin
                if (clrPend) begin
                    state_d        = SERVICE;
                    clr_vec[sel_q] = 1'b1;
                end else if (!eligible[sel_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (intReturn) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (pend_q & ~clr_vec) | rise;
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            irq_prev_q <= '0;
            pend_q     <= '0;
            mask_q     <= '1;
            en_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        intPending = (state_q == PEND);
        inService  = (state_q == SERVICE);
        hvpiAddr   = addr_q;
        pendingOut = pend_q;
        maskOut    = mask_q;
    end

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: a behavioural model predicts the
// outputs after every clock edge; a monitor compares them. A second instance
// with a high vector base exercises address wrap-around.
module tb_int_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq, maskIn;
    logic        MASKld, MASKclr, intDisable, intEnable, clrPend, intReturn;
    logic        intPending, inService, intPending2, inService2;
    logic [15:0] hvpiAddr, hvpiAddr2;
    logic [7:0]  pendingOut, maskOut, pendingOut2, maskOut2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    int_controller u_dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .maskIn(maskIn),
        .MASKld(MASKld), .MASKclr(MASKclr), .intDisable(intDisable),
        .intEnable(intEnable), .clrPend(clrPend), .intReturn(intReturn),
        .intPending(intPending), .hvpiAddr(hvpiAddr), .inService(inService),
        .pendingOut(pendingOut), .maskOut(maskOut)
    );

    int_controller #(.VEC_BASE(16'hFFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .irq(irq), .maskIn(maskIn),
        .MASKld(MASKld), .MASKclr(MASKclr), .intDisable(intDisable),
        .intEnable(intEnable), .clrPend(clrPend), .intReturn(intReturn),
        .intPending(intPending2), .hvpiAddr(hvpiAddr2), .inService(inService2),
        .pendingOut(pendingOut2), .maskOut(maskOut2)
    );

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_PRESENT = 1, M_SERVE = 2;
    int       m_mode;
    bit [7:0] m_pend, m_prev, m_mask;
    bit       m_en;
    int       m_line;
    int       m_addr, m_addr2;

    typedef struct {
        bit       ip;
        bit       is;
        bit [15:0] a;
        bit [15:0] a2;
        bit [7:0] p;
        bit [7:0] m;
    } exp_t;
    exp_t sb[$];

    function automatic int lowest(bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int vec(int base, int line);
        return (base + line * 4) % 65536;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pend = '0; m_prev = '0; m_mask = 8'hFF;
        m_en = 1'b0; m_line = 0; m_addr = 0; m_addr2 = 0;
    endtask

    task automatic model_edge();
        bit [7:0] rising, elig, cleared;
        rising  = irq & ~m_prev;
        elig    = m_pend & ~m_mask;
        cleared = '0;
        if (m_mode == M_IDLE) begin
            if (m_en && elig != 0) begin
                m_line  = lowest(elig);
                m_addr  = vec(16'hFF00, m_line);
                m_addr2 = vec(16'hFFFC, m_line);
                m_mode  = M_PRESENT;
            end
        end else if (m_mode == M_PRESENT) begin
            if (clrPend) begin
                cleared[m_line] = 1'b1;
                m_mode = M_SERVE;
            end else if (!elig[m_line]) begin
                m_mode = M_IDLE;
            end
        end else if (intReturn) begin
            m_mode = M_IDLE;
        end
        m_pend = (m_pend & ~cleared) | rising;
        m_prev = irq;
        if (MASKclr) m_mask = '0;
        else if (MASKld) m_mask = maskIn;
        if (intDisable) m_en = 1'b0;
        else if (intEnable) m_en = 1'b1;
    endtask

    // One clock: predict, queue expectation, advance, drop single-cycle strobes
    task automatic step();
        exp_t e;
        model_edge();
        e.ip = (m_mode == M_PRESENT);
        e.is = (m_mode == M_SERVE);
        e.a  = 16'(m_addr);
        e.a2 = 16'(m_addr2);
        e.p  = m_pend;
        e.m  = m_mask;
        sb.push_back(e);
        @(posedge clk); #2;
        MASKld = 0; MASKclr = 0; intDisable = 0; intEnable = 0;
        clrPend = 0; intReturn = 0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (intPending !== e.ip || inService !== e.is || hvpiAddr !== e.a ||
                    hvpiAddr2 !== e.a2 || pendingOut !== e.p || maskOut !== e.m) begin
                    fails++;
                    $display("FAIL snapshot @%0t: got ip=%b is=%b a=%h a2=%h p=%h m=%h expected ip=%b is=%b a=%h a2=%h p=%h m=%h",
                             $time, intPending, inService, hvpiAddr, hvpiAddr2, pendingOut, maskOut,
                             e.ip, e.is, e.a, e.a2, e.p, e.m);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0; irq = 0; maskIn = 0;
        MASKld = 0; MASKclr = 0; intDisable = 0; intEnable = 0;
        clrPend = 0; intReturn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset intPending", intPending, 0);
        chk("reset inService", inService, 0);
        chk("reset hvpiAddr", hvpiAddr, 0);
        chk("reset pendingOut", pendingOut, 0);
        chk("reset maskOut", maskOut, 8'hFF);
        rst_n = 1;

        // Basic request on line 3
        MASKclr = 1; intEnable = 1; step();
        irq = 8'h08; step();
        chk("basic not yet pending", intPending, 0);
        irq = 8'h00; step();
        chk("basic intPending", intPending, 1);
        chk("basic hvpiAddr", hvpiAddr, 16'hFF0C);
        chk("wrap hvpiAddr", hvpiAddr2, 16'h0008);
        clrPend = 1; step();
        chk("basic inService", inService, 1);
        chk("basic pendingOut", pendingOut, 0);
        intReturn = 1; step();
        chk("basic idle", {intPending, inService}, 0);

        // Priority and freeze
        irq = 8'h80; step();
        irq = 8'h81; step();
        chk("freeze addr", hvpiAddr, 16'hFF1C);
        irq = 8'h00; step();
        chk("freeze held", hvpiAddr, 16'hFF1C);
        clrPend = 1; step();
        chk("freeze in service", hvpiAddr, 16'hFF1C);
        intReturn = 1; step();
        step();
        chk("second request addr", hvpiAddr, 16'hFF00);
        clrPend = 1; step();
        intReturn = 1; step();

        // Mask withdraw
        irq = 8'h04; step();
        irq = 8'h00; step();
        chk("mask presented", hvpiAddr, 16'hFF08);
        maskIn = 8'h04; MASKld = 1; step();
        step();
        chk("withdraw intPending", intPending, 0);
        chk("withdraw pendingOut", pendingOut, 8'h04);
        MASKclr = 1; step();
        step();
        chk("re-presented", intPending, 1);
        clrPend = 1; step();
        intReturn = 1; step();

        // Disable and hold
        intDisable = 1; step();
        irq = 8'h01; step();
        irq = 8'h00; step();
        step();
        chk("disabled intPending", intPending, 0);
        chk("disabled pendingOut", pendingOut, 8'h01);
        intEnable = 1; step();
        step();
        chk("enabled intPending", intPending, 1);
        clrPend = 1; step();
        intReturn = 1; step();

        // Simultaneous set and clear on line 1
        irq = 8'h02; step();
        irq = 8'h00; step();
        irq = 8'h02; clrPend = 1; step();
        chk("set-wins inService", inService, 1);
        chk("set-wins pending bit", pendingOut[1], 1);
        irq = 8'h00; intReturn = 1; step();
        step();
        chk("line1 re-presented", hvpiAddr, 16'hFF04);
        clrPend = 1; step();
        chk("mid-service", inService, 1);

        // Asynchronous reset mid-service
        rst_n = 0; #1;
        chk("async inService", inService, 0);
        chk("async hvpiAddr", hvpiAddr, 0);
        chk("async maskOut", maskOut, 8'hFF);
        chk("async pendingOut", pendingOut, 0);
        model_reset();
        @(posedge clk); #2;
        rst_n = 1;

        // Randomized traffic
        MASKclr = 1; intEnable = 1; step();
        for (int n = 0; n < 400; n++) begin
            irq        = 8'($urandom);
            MASKld     = ($urandom_range(0, 9) == 0);
            maskIn     = 8'($urandom);
            MASKclr    = ($urandom_range(0, 9) == 0);
            intDisable = ($urandom_range(0, 11) == 0);
            intEnable  = ($urandom_range(0, 3) == 0);
            clrPend    = ($urandom_range(0, 1) == 0);
            intReturn  = ($urandom_range(0, 2) == 0);
            step();
        end

        #5;
        chk("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
